// File: rtl/ibex_rf_pkg.sv
// Shared types and helpers for the register-file write queue.
// Holds the queue entry layout and the youngest-match forwarding search.
package ibex_rf_pkg;

    localparam int unsigned RegAddrW     = 5;
    localparam int unsigned MaxDataWidth = 32;
    localparam int unsigned MaxDepth     = 16;
    localparam int unsigned MaxDepthW    = 4;

    typedef struct packed {
        logic [RegAddrW-1:0]     addr;
        logic [MaxDataWidth-1:0] data;
    } wq_entry_t;

    typedef struct packed {
        logic                 hit;
        logic [MaxDepthW-1:0] idx;
    } fwd_sel_t;

    // match is in age order (bit 0 = oldest), so the last set bit is the youngest writer.
    function automatic fwd_sel_t fwd_select(input logic [MaxDepth-1:0] match);
        fwd_sel_t sel;
        sel.hit = 1'b0;
        sel.idx = '0;
        for (int i = 0; i < MaxDepth; i++) begin
            if (match[i]) begin
                sel.hit = 1'b1;
                sel.idx = MaxDepthW'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ibex_rf_write_queue_if.sv
// Bundle of writeback, ID operand and SRAM port signals around the write queue.
// The slave modport is the queue itself; master is the surrounding core and SRAM.
interface ibex_rf_write_queue_if
    import ibex_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic                 wb_we_i;
    logic [RegAddrW-1:0]  wb_waddr_i;
    logic [DataWidth-1:0] wb_wdata_i;
    logic                 id_valid_i;
    logic                 id_rb_used_i;
    logic [RegAddrW-1:0]  id_raddr_a_i;
    logic [RegAddrW-1:0]  id_raddr_b_i;
    logic [DataWidth-1:0] rdata_a_o;
    logic [DataWidth-1:0] rdata_b_o;
    logic [RegAddrW-1:0]  rf_raddr_a_o;
    logic [RegAddrW-1:0]  rf_addr_b_o;
    logic                 rf_we_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic [DataWidth-1:0] rf_rdata_a_i;
    logic [DataWidth-1:0] rf_rdata_b_i;
    logic                 wb_stall_o;
    logic                 id_stall_o;
    logic [CntW-1:0]      occupancy_o;

    modport slave (
        input  wb_we_i, wb_waddr_i, wb_wdata_i,
        input  id_valid_i, id_rb_used_i, id_raddr_a_i, id_raddr_b_i,
        input  rf_rdata_a_i, rf_rdata_b_i,
        output rdata_a_o, rdata_b_o, rf_raddr_a_o, rf_addr_b_o, rf_we_o, rf_wdata_o,
        output wb_stall_o, id_stall_o, occupancy_o
    );

    modport master (
        output wb_we_i, wb_waddr_i, wb_wdata_i,
        output id_valid_i, id_rb_used_i, id_raddr_a_i, id_raddr_b_i,
        output rf_rdata_a_i, rf_rdata_b_i,
        input  rdata_a_o, rdata_b_o, rf_raddr_a_o, rf_addr_b_o, rf_we_o, rf_wdata_o,
        input  wb_stall_o, id_stall_o, occupancy_o
    );

endinterface

// File: rtl/ibex_rf_wq_fifo.sv
// Write-queue storage: circular buffer with head/tail/count.
// All entries are exposed in age order (index 0 = head) for forwarding.
module ibex_rf_wq_fifo
    import ibex_rf_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            push,
    input  wq_entry_t       push_entry,
    input  logic            pop,
    output wq_entry_t       entries [Depth],
    output logic [Depth-1:0] valid,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    wq_entry_t       mem_reg [Depth];
    logic [PtrW-1:0] head_reg;
    logic [PtrW-1:0] tail_reg;
    logic [CntW-1:0] count_reg;

    // Storage is left unreset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                mem_reg[tail_reg] <= push_entry;
                tail_reg          <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_reg + CntW'(push) - CntW'(pop);
        end
    end

    for (genvar gi = 0; gi < Depth; gi++) begin : g_view
        logic [PtrW-1:0] slot;
        assign slot        = head_reg + PtrW'(gi);
        assign entries[gi] = mem_reg[slot];
        assign valid[gi]   = (CntW'(gi) < count_reg);
    end

    assign count = count_reg;
    assign full  = (count_reg == CntW'(Depth));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/ibex_rf_write_queue.sv
// Writeback-to-SRAM write queue: drains through the shared port when ID leaves it free,
// forwards pending data to ID reads, and forces a drain after prolonged starvation.
module ibex_rf_write_queue
    import ibex_rf_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_rf_write_queue_if.slave  bus
);

    localparam int unsigned CntW    = $clog2(Depth) + 1;
    localparam int unsigned DepthW  = $clog2(Depth);
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);

    wq_entry_t        entries [Depth];
    wq_entry_t        push_entry;
    logic [Depth-1:0] valid;
    logic [CntW-1:0]  count;
    logic             full;
    logic             empty;

    logic [StarveW-1:0] starve_reg;
    logic [StarveW-1:0] starve_next;
    logic               forced;
    logic               drain;
    logic               wr_req;
    logic               push;

    assign push_entry.addr = bus.wb_waddr_i;
    assign push_entry.data = MaxDataWidth'(bus.wb_wdata_i);

    ibex_rf_wq_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk        (clk_i),
        .srst       (rst_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .entries    (entries),
        .valid      (valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign forced = (starve_reg == StarveW'(StarveLimit));
    assign drain  = !empty && (!(bus.id_valid_i && bus.id_rb_used_i) || forced);
    assign wr_req = bus.wb_we_i && (bus.wb_waddr_i != '0);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push   = wr_req && (!full || drain);

    assign bus.wb_stall_o   = wr_req && full && !drain;
    assign bus.id_stall_o   = forced;
    assign bus.rf_we_o      = drain;
    assign bus.rf_addr_b_o  = drain ? entries[0].addr : bus.id_raddr_b_i;
    assign bus.rf_wdata_o   = entries[0].data[DataWidth-1:0];
    assign bus.rf_raddr_a_o = bus.id_raddr_a_i;
    assign bus.occupancy_o  = count;

    always_comb begin
        starve_next = starve_reg;
        if (empty || drain) begin
            starve_next = '0;
        end else if (!forced) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    // Operand 0 is A (SRAM port 1), operand 1 is B (SRAM port 2).
    logic [RegAddrW-1:0]  raddr     [2];
    logic [DataWidth-1:0] sram_data [2];
    logic [DataWidth-1:0] fwd_data  [2];

    assign raddr[0]     = bus.id_raddr_a_i;
    assign raddr[1]     = bus.id_raddr_b_i;
    assign sram_data[0] = bus.rf_rdata_a_i;
    assign sram_data[1] = bus.rf_rdata_b_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [MaxDepth-1:0] match;
        fwd_sel_t            sel;
        logic                hit;
        logic [DepthW-1:0]   idx;

        always_comb begin
            match = '0;
            for (int k = 0; k < Depth; k++) begin
                match[k] = valid[k] && (entries[k].addr == raddr[gi]);
            end
        end

        assign sel = fwd_select(match);
        // The range test keeps an out-of-depth index from ever selecting a slot.
        assign hit = sel.hit && (sel.idx < MaxDepthW'(Depth));
        assign idx = sel.idx[DepthW-1:0];

        assign fwd_data[gi] = (raddr[gi] == '0) ? '0 :
                              hit               ? entries[idx].data[DataWidth-1:0] :
                                                  sram_data[gi];
    end

    assign bus.rdata_a_o = fwd_data[0];
    assign bus.rdata_b_o = fwd_data[1];

endmodule

// File: tb/tb_ibex_rf_write_queue.sv
// Directed bench for the RF write queue: SRAM model, drain scoreboard and
// immediate-assertion checks on stalls, occupancy and forwarding.
module tb_ibex_rf_write_queue;
    import ibex_rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_rf_write_queue_if #(.DataWidth(32), .Depth(2)) bus ();

    ibex_rf_write_queue #(
        .DataWidth   (32),
        .Depth       (2),
        .StarveLimit (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // SRAM model; x0 holds junk so that zero-forcing on reads is observable.
    logic [31:0] sram [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) sram[i] <= 32'h0;
            sram[0] <= 32'hBAD0_0000;
            sram[8] <= 32'h0000_00A8;
            sram[9] <= 32'h0000_00A9;
        end else if (bus.rf_we_o === 1'b1) begin
            sram[bus.rf_addr_b_o] <= bus.rf_wdata_o;
        end
    end
    assign bus.rf_rdata_a_i = sram[bus.rf_raddr_a_o];
    assign bus.rf_rdata_b_i = sram[bus.rf_addr_b_o];

    wq_entry_t sb[$];
    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        bus.wb_we_i    = we;
        bus.wb_waddr_i = addr;
        bus.wb_wdata_i = data;
    endtask

    task automatic drive_id(input logic v, input logic rb, input logic [4:0] ra, input logic [4:0] rbaddr);
        bus.id_valid_i   = v;
        bus.id_rb_used_i = rb;
        bus.id_raddr_a_i = ra;
        bus.id_raddr_b_i = rbaddr;
    endtask

    task automatic expect_drain(input logic [4:0] addr, input logic [31:0] data);
        wq_entry_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Every observed drain is matched against the oldest expected write, then the clock advances.
    task automatic advance();
        wq_entry_t e;
        if (bus.rf_we_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("drain_with_empty_sb", 32'(bus.rf_we_o), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("drain_addr", 32'(bus.rf_addr_b_o), 32'(e.addr));
                chk("drain_data", bus.rf_wdata_o, e.data);
                $display("drain x%0d = %h", bus.rf_addr_b_o, bus.rf_wdata_o);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b0, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_occupancy", 32'(bus.occupancy_o), 32'h0);
        chk("rst_rf_we", 32'(bus.rf_we_o), 32'h0);
        chk("rst_wb_stall", 32'(bus.wb_stall_o), 32'h0);
        chk("rst_id_stall", 32'(bus.id_stall_o), 32'h0);
        advance();

        // Single write drained the next cycle
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
        expect_drain(5'd5, 32'hDEADBEEF);
        settle();
        chk("t1_wb_stall", 32'(bus.wb_stall_o), 32'h0);
        chk("t1_no_drain_yet", 32'(bus.rf_we_o), 32'h0);
        advance();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        chk("t1_occ1", 32'(bus.occupancy_o), 32'h1);
        chk("t1_rf_we", 32'(bus.rf_we_o), 32'h1);
        chk("t1_addr", 32'(bus.rf_addr_b_o), 32'h5);
        chk("t1_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        advance();
        settle();
        chk("t1_occ0", 32'(bus.occupancy_o), 32'h0);
        chk("t1_sram5", sram[5], 32'hDEADBEEF);
        advance();

        // Two writes to x3 while port B is busy; youngest is forwarded
        drive_id(1'b1, 1'b1, 5'd3, 5'd3);
        drive_wb(1'b1, 5'd3, 32'h11);
        expect_drain(5'd3, 32'h11);
        settle();
        chk("t2_blocked", 32'(bus.rf_we_o), 32'h0);
        advance();
        drive_wb(1'b1, 5'd3, 32'h22);
        expect_drain(5'd3, 32'h22);
        settle();
        chk("t2_fwd_a_older", bus.rdata_a_o, 32'h11);
        advance();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        chk("t2_fwd_a", bus.rdata_a_o, 32'h22);
        chk("t2_fwd_b", bus.rdata_b_o, 32'h22);
        chk("t2_addr_b_id", 32'(bus.rf_addr_b_o), 32'h3);
        chk("t2_occ2", 32'(bus.occupancy_o), 32'h2);
        advance();
        drive_id(1'b0, 1'b0, 5'd3, 5'd3);
        settle();
        chk("t2_drain1", 32'(bus.rf_we_o), 32'h1);
        chk("t2_fwd_during_drain", bus.rdata_a_o, 32'h22);
        advance();
        settle();
        chk("t2_fwd_head", bus.rdata_a_o, 32'h22);
        advance();
        settle();
        chk("t2_occ0", 32'(bus.occupancy_o), 32'h0);
        chk("t2_sram3", sram[3], 32'h22);
        advance();

        // Full queue stalls, then push and pop in the same cycle
        drive_id(1'b1, 1'b1, 5'd0, 5'd0);
        drive_wb(1'b1, 5'd1, 32'h101);
        expect_drain(5'd1, 32'h101);
        settle();
        advance();
        drive_wb(1'b1, 5'd2, 32'h202);
        expect_drain(5'd2, 32'h202);
        settle();
        chk("t3_no_stall", 32'(bus.wb_stall_o), 32'h0);
        advance();
        drive_wb(1'b1, 5'd4, 32'h404);
        settle();
        chk("t3_stall", 32'(bus.wb_stall_o), 32'h1);
        chk("t3_occ_full", 32'(bus.occupancy_o), 32'h2);
        chk("t3_id_stall", 32'(bus.id_stall_o), 32'h0);
        advance();
        drive_id(1'b0, 1'b0, 5'd0, 5'd0);
        expect_drain(5'd4, 32'h404);
        settle();
        chk("t3_stall_clear", 32'(bus.wb_stall_o), 32'h0);
        chk("t3_drain", 32'(bus.rf_we_o), 32'h1);
        chk("t3_occ_pp", 32'(bus.occupancy_o), 32'h2);
        advance();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        chk("t3_occ_after_pp", 32'(bus.occupancy_o), 32'h2);
        advance();
        settle();
        chk("t3_occ1", 32'(bus.occupancy_o), 32'h1);
        advance();
        settle();
        chk("t3_occ0", 32'(bus.occupancy_o), 32'h0);
        advance();

        // Starvation forces a drain on the fifth blocked cycle
        drive_id(1'b1, 1'b1, 5'd0, 5'd0);
        drive_wb(1'b1, 5'd7, 32'h77);
        expect_drain(5'd7, 32'h77);
        settle();
        advance();
        drive_wb(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_no_force", 32'(bus.id_stall_o), 32'h0);
            chk("t4_blocked", 32'(bus.rf_we_o), 32'h0);
            advance();
        end
        settle();
        chk("t4_forced_stall", 32'(bus.id_stall_o), 32'h1);
        chk("t4_forced_we", 32'(bus.rf_we_o), 32'h1);
        chk("t4_forced_addr", 32'(bus.rf_addr_b_o), 32'h7);
        advance();
        settle();
        chk("t4_stall_clear", 32'(bus.id_stall_o), 32'h0);
        chk("t4_we_clear", 32'(bus.rf_we_o), 32'h0);
        chk("t4_occ0", 32'(bus.occupancy_o), 32'h0);
        chk("t4_sram7", sram[7], 32'h77);
        advance();

        // x0 writes are dropped even when full; x0 reads return zero
        drive_wb(1'b1, 5'd8, 32'h88);
        expect_drain(5'd8, 32'h88);
        settle();
        advance();
        drive_wb(1'b1, 5'd9, 32'h99);
        expect_drain(5'd9, 32'h99);
        settle();
        advance();
        drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        settle();
        chk("t5_x0_no_stall", 32'(bus.wb_stall_o), 32'h0);
        chk("t5_occ_full", 32'(bus.occupancy_o), 32'h2);
        chk("t5_x0_read_a", bus.rdata_a_o, 32'h0);
        chk("t5_x0_read_b", bus.rdata_b_o, 32'h0);
        advance();
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        chk("t5_occ_still2", 32'(bus.occupancy_o), 32'h2);
        advance();

        // Reset with two queued entries discards them
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        sb.delete();
        drive_id(1'b0, 1'b0, 5'd8, 5'd9);
        settle();
        chk("t6_occ0", 32'(bus.occupancy_o), 32'h0);
        chk("t6_rf_we", 32'(bus.rf_we_o), 32'h0);
        chk("t6_read_a_sram", bus.rdata_a_o, 32'h0000_00A8);
        chk("t6_read_b_sram", bus.rdata_b_o, 32'h0000_00A9);
        advance();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
